// File: rtl/ps2_host_ctrl_if.sv
// User-side handshake bundle for ps2_host_ctrl: transmit request/response
// and received-byte reporting. The controller takes the slave modport, the
// user logic (or a bench) takes the master modport.
interface ps2_host_ctrl_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_ack_err, rx_valid, rx_data, rx_err, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_ack_err, rx_valid, rx_data, rx_err, busy
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// PS/2 host line controller. Owns the open-collector clock/data pair,
// receives device frames (start, 8 data LSB first, odd parity, stop) and
// transmits host frames with the inhibit / request-to-send sequence.
// Optional feature: define PS2_TIMEOUT_EN to abort a frame when the PS/2
// clock stalls for TIMEOUT_TICKS cycles mid-frame.
module ps2_host_ctrl #(
  parameter int FILTER_LEN    = 4,
  parameter int INHIBIT_TICKS = 5000,
  parameter int TIMEOUT_TICKS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic ps2_clk_oe,
  output logic ps2_dat_oe,
  ps2_host_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RX, TX_INH, TX_RTS, TX_DATA, TX_ACK, WAIT_IDLE} state_t;

  localparam int INH_W = $clog2(INHIBIT_TICKS + 1);

  // Filtered line levels: bit 0 = PS/2 clock, bit 1 = PS/2 data.
  logic [1:0] pin_in;
  logic [1:0] filt;
  assign pin_in = {ps2_dat_i, ps2_clk_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic                  s1_reg, s2_reg, f_reg;
      logic [FILTER_LEN-1:0] hist_reg;
      // Synchronise the pin, then only follow it after FILTER_LEN equal samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg   <= 1'b1;
          s2_reg   <= 1'b1;
          hist_reg <= '1;
          f_reg    <= 1'b1;
        end else begin
          s1_reg   <= pin_in[gi];
          s2_reg   <= s1_reg;
          hist_reg <= {hist_reg[FILTER_LEN-2:0], s2_reg};
          if (&hist_reg)
            f_reg <= 1'b1;
          else if (~|hist_reg)
            f_reg <= 1'b0;
        end
      end
      assign filt[gi] = f_reg;
    end
  endgenerate

  logic clk_f, dat_f, clk_prev_reg, fall;
  assign clk_f = filt[0];
  assign dat_f = filt[1];
  assign fall  = clk_prev_reg & ~clk_f;

  state_t            state_reg, state_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [10:0]       shift_reg, shift_next;
  logic [INH_W-1:0]  tick_reg, tick_next;
  logic              clk_oe_reg, clk_oe_next, dat_oe_reg, dat_oe_next;
  logic [7:0]        rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next, rx_err_reg, rx_err_next;
  logic              tx_done_reg, tx_done_next, ack_err_reg, ack_err_next;
  logic [10:0]       frame;

  // RX frame as it will look once the current data sample is shifted in.
  assign frame = {dat_f, shift_reg[10:1]};

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] to_reg, to_next;
  logic            clk_edge, to_active;
  assign clk_edge  = clk_prev_reg ^ clk_f;
  assign to_active = (state_reg == RX) || (state_reg == TX_DATA) || (state_reg == TX_ACK);

  // Stall counter: runs mid-frame, cleared by any filtered clock edge.
  always_comb to_next = (to_active && !clk_edge) ? to_reg + TO_W'(1) : '0;

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_reg <= '0;
    else        to_reg <= to_next;
  end
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tick_next     = tick_reg;
    clk_oe_next   = clk_oe_reg;
    dat_oe_next   = dat_oe_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_err_next   = 1'b0;
    tx_done_next  = 1'b0;
    ack_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        clk_oe_next = 1'b0;
        dat_oe_next = 1'b0;
        if (fall) begin
          // Device start bit wins over a simultaneous host request.
          state_next   = RX;
          bit_cnt_next = 4'd1;
          shift_next   = frame;
        end else if (bus.tx_valid) begin
          state_next  = TX_INH;
          shift_next  = {2'b11, ~^bus.tx_data, bus.tx_data};
          tick_next   = '0;
          clk_oe_next = 1'b1;
        end
      end
      RX: begin
        if (fall) begin
          shift_next   = frame;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd10) begin
            state_next = WAIT_IDLE;
            if (!frame[0] && (^frame[9:1]) && frame[10]) begin
              rx_data_next  = frame[8:1];
              rx_valid_next = 1'b1;
            end else begin
              rx_err_next = 1'b1;
            end
          end
        end
      end
      TX_INH: begin
        tick_next = tick_reg + INH_W'(1);
        if (tick_reg == INH_W'(INHIBIT_TICKS - 1)) begin
          state_next  = TX_RTS;
          dat_oe_next = 1'b1;
        end
      end
      TX_RTS: begin
        clk_oe_next  = 1'b0;
        bit_cnt_next = 4'd0;
        state_next   = TX_DATA;
      end
      TX_DATA: begin
        if (fall) begin
          dat_oe_next  = ~shift_reg[0];
          shift_next   = {1'b1, shift_reg[10:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd9) state_next = TX_ACK;
        end
      end
      TX_ACK: begin
        if (fall) begin
          tx_done_next = 1'b1;
          ack_err_next = dat_f;
          state_next   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        clk_oe_next = 1'b0;
        dat_oe_next = 1'b0;
        if (clk_f && dat_f) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef PS2_TIMEOUT_EN
    if (to_active && !clk_edge && to_reg == TO_W'(TIMEOUT_TICKS - 1)) begin
      state_next  = WAIT_IDLE;
      clk_oe_next = 1'b0;
      dat_oe_next = 1'b0;
      if (state_reg == RX) begin
        rx_err_next = 1'b1;
      end else begin
        tx_done_next = 1'b1;
        ack_err_next = 1'b1;
      end
    end
`endif
  end

  // State, datapath and registered pin/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      clk_prev_reg <= 1'b1;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tick_reg     <= '0;
      clk_oe_reg   <= 1'b0;
      dat_oe_reg   <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
      tx_done_reg  <= 1'b0;
      ack_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clk_prev_reg <= clk_f;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tick_reg     <= tick_next;
      clk_oe_reg   <= clk_oe_next;
      dat_oe_reg   <= dat_oe_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_err_reg   <= rx_err_next;
      tx_done_reg  <= tx_done_next;
      ack_err_reg  <= ack_err_next;
    end
  end

  assign ps2_clk_oe     = clk_oe_reg;
  assign ps2_dat_oe     = dat_oe_reg;
  assign bus.tx_ready   = rst_n & (state_reg == IDLE) & ~fall;
  assign bus.tx_done    = tx_done_reg;
  assign bus.tx_ack_err = ack_err_reg;
  assign bus.rx_valid   = rx_valid_reg;
  assign bus.rx_data    = rx_data_reg;
  assign bus.rx_err     = rx_err_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Self-checking bench for ps2_host_ctrl: a PS/2 device model drives the
// open-collector lines, random frames are checked against a frame-level model.
module tb_ps2_host_ctrl;
  localparam int H   = 25;    // device half bit period in clk cycles
  localparam int INH = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe;
  logic line_clk, line_dat;

  always #10 clk = ~clk;

  assign line_clk = ~(ps2_clk_oe | dev_clk_low);
  assign line_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_ctrl_if bus ();

  ps2_host_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (line_clk),
    .ps2_dat_i (line_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .bus       (bus.slave)
  );

  int n_chk = 0, n_pass = 0;
  int rxv_cnt = 0, rxe_cnt = 0, txd_cnt = 0, ack_cnt = 0, acc_cnt = 0;
  logic [7:0] exp_rx = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid)   rxv_cnt++;
    if (bus.rx_err)     rxe_cnt++;
    if (bus.tx_done)    txd_cnt++;
    if (bus.tx_ack_err) ack_cnt++;
  end

  // Handshake acceptance counter.
  always @(posedge clk) if (rst_n && bus.tx_valid && bus.tx_ready) acc_cnt++;

  // Device clocks out nbits of an 11-bit frame built from the byte and error flags.
  task automatic dev_send(input logic [7:0] d, input logic bs, bp, bt, input int nbits);
    logic [10:0] f;
    f = {~bt, (~^d) ^ bp, d, bs};
    for (int i = 0; i < nbits; i++) begin
      dev_dat_low = ~f[i];
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (H) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_not_busy(input int limit);
    for (int i = 0; i < limit && bus.busy; i++) @(negedge clk);
    check_val("idle_reached", bus.busy, 0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic bs, bp, bt);
    int v0, e0;
    logic good;
    v0 = rxv_cnt; e0 = rxe_cnt;
    good = !bs && !bp && !bt;
    dev_send(d, bs, bp, bt, 11);
    wait_not_busy(500);
    if (good) exp_rx = d;
    check_val("rx_valid_cnt", rxv_cnt - v0, good);
    check_val("rx_err_cnt", rxe_cnt - e0, !good);
    check_val("rx_data", bus.rx_data, exp_rx);
    $display("rx  byte=%02h start_err=%0d par_err=%0d stop_err=%0d rx_data=%02h", d, bs, bp, bt, bus.rx_data);
  endtask

  // Issue a request and hold it until accepted, then scramble tx_data.
  task automatic tx_request(input logic [7:0] d);
    int a0;
    a0 = acc_cnt;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    for (int i = 0; i < 2000 && acc_cnt == a0; i++) @(negedge clk);
    check_val("tx_accept", acc_cnt - a0, 1);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  // Device side of a host transmit: wait for RTS release, clock 10 bits in, then ack.
  task automatic dev_recv(input logic ack_bad, input int nclk, output logic [9:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 20000) begin
      w++;
      @(negedge clk);
    end
    check_val("rts_seen", (w < 20000), 1);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10) dev_dat_low = ~ack_bad;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i < 10) bits[i] = line_dat;
      dev_clk_low = 1'b0;
    end
    repeat (H) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] d, input logic ack_bad);
    int d0, k0, inh, rts;
    logic [9:0] bits;
    d0 = txd_cnt; k0 = ack_cnt;
    tx_request(d);
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 20000) begin inh++; @(negedge clk); end
    rts = 0;
    while (ps2_clk_oe && ps2_dat_oe && rts < 10) begin rts++; @(negedge clk); end
    check_val("inhibit_cycles", inh, INH);
    check_val("rts_cycles", rts, 1);
    dev_recv(ack_bad, 11, bits);
    wait_not_busy(500);
    check_val("tx_bits", bits, {1'b1, ~^d, d});
    check_val("tx_done_cnt", txd_cnt - d0, 1);
    check_val("tx_ack_err_cnt", ack_cnt - k0, ack_bad);
    $display("tx  byte=%02h ack_bad=%0d inhibit=%0d bits=%03h", d, ack_bad, inh, bits);
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] bits;
    int sel, v0, d0, found, a0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset state.
    repeat (5) @(negedge clk);
    check_val("rst_clk_oe", ps2_clk_oe, 0);
    check_val("rst_dat_oe", ps2_dat_oe, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_rx_data", bus.rx_data, 8'h00);
    check_val("rst_pulses", {bus.rx_valid, bus.rx_err, bus.tx_done, bus.tx_ack_err, bus.tx_ready}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("tx_ready_idle", bus.tx_ready, 1);

    // Directed receive: good byte, then parity error keeps old data.
    rx_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    rx_frame(8'hF0, 1'b0, 1'b1, 1'b0);

    // Random receive frames with occasional framing faults.
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom);
      sel = $urandom_range(0, 5);
      rx_frame(d, sel == 2, sel == 0, sel == 1);
    end

    // Directed and random transmits.
    tx_frame(8'hED, 1'b0);
    tx_frame(8'($urandom), 1'($urandom));
    tx_frame(8'($urandom), 1'b1);

    // Start-bit fall and request in the same cycle: receive first, then transmit.
    d = 8'($urandom);
    v0 = rxv_cnt; d0 = txd_cnt; a0 = acc_cnt; found = 0;
    fork
      dev_send(8'h5A, 1'b0, 1'b0, 1'b0, 11);
      begin
        for (int i = 0; i < 2000 && found == 0; i++) begin
          @(negedge clk);
          if (!bus.busy && !bus.tx_ready) begin
            found = 1;
            bus.tx_valid = 1'b1;
            bus.tx_data  = d;
          end
        end
        for (int i = 0; i < 5000 && acc_cnt == a0; i++) @(negedge clk);
        check_val("rx_before_tx", rxv_cnt - v0, 1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~d;
      end
    join
    check_val("collision_seen", found, 1);
    exp_rx = 8'h5A;
    check_val("collision_rx_data", bus.rx_data, exp_rx);
    dev_recv(1'b0, 11, bits);
    wait_not_busy(500);
    check_val("collision_tx_bits", bits, {1'b1, ~^d, d});
    check_val("collision_accepts", acc_cnt - a0, 1);
    check_val("collision_tx_done", txd_cnt - d0, 1);
    $display("col rx=5a tx=%02h bits=%03h", d, bits);

    // Reset in the middle of a transmit data phase.
    d = 8'($urandom) & 8'hF7;
    d0 = txd_cnt;
    tx_request(d);
    dev_recv(1'b0, 4, bits);
    check_val("mid_tx_dat_oe", ps2_dat_oe, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_rx = 8'h00;
    check_val("post_rst_busy", bus.busy, 0);
    check_val("post_rst_tx_done", txd_cnt - d0, 0);
    check_val("post_rst_rx_data", bus.rx_data, exp_rx);
    check_val("post_rst_ready", bus.tx_ready, 1);
    $display("rst mid-tx byte=%02h released", d);

`ifdef PS2_TIMEOUT_EN
    // Device stalls after 4 bits; the frame must abort with rx_err.
    v0 = rxe_cnt;
    dev_send(8'($urandom), 1'b0, 1'b0, 1'b0, 4);
    for (int i = 0; i < 110000 && rxe_cnt == v0; i++) @(negedge clk);
    check_val("timeout_rx_err", rxe_cnt - v0, 1);
    wait_not_busy(500);
    $display("timeout rx_err seen");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
`ifdef PS2_TIMEOUT_EN
    repeat (400000) @(posedge clk);
`else
    repeat (95000) @(posedge clk);
`endif
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
